// File: rtl/conv1_pxl_streamer.sv
// conv1_pxl_streamer: raster-order frame source for the layer-1 conv/pool input.
// Issues SRAM reads, then presents pixels one cycle later with sof/eol/eof/done.
module conv1_pxl_streamer #(
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int LINE_GAP = 0
) (
  input  logic              pxl_clk,
  input  logic              pxl_rst_b,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              sram_rd_en_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [DATA_W-1:0] sram_rdata_i,
  output logic              sof_o,
  output logic              data_valid_o,
  output logic [DATA_W-1:0] pxl_data_o,
  output logic              eol_o,
  output logic              eof_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [3:0] GAP_LAST =
    (LINE_GAP > 0) ? 4'(LINE_GAP - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_STREAM,
    S_GAP,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [3:0]        gap_q, gap_d;
  logic              dv_q, dv_d;
  logic              eol_q, eol_d;
  logic              eof_q, eof_d;
  logic              line_last;
  logic              frame_last;
  logic              rd_eol;
  logic              rd_eof;

  // Next-state, read-side issue and one-cycle data-side delay
  always_comb begin
    line_last  = (col_q == COL_LAST);
    frame_last = (row_q == ROW_LAST);
    rd_eol     = rd_en_q & line_last;
    rd_eof     = rd_eol & frame_last;
    state_d    = state_q;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    col_d      = col_q;
    row_d      = row_q;
    gap_d      = gap_q;
    dv_d       = rd_en_q;
    eol_d      = rd_eol;
    eof_d      = rd_eof;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_SOF;
          rd_en_d = 1'b1;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
          gap_d   = '0;
        end
      end
      S_SOF, S_STREAM: begin
        if (!line_last) begin
          state_d = S_STREAM;
          rd_en_d = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          col_d   = col_q + CW'(1);
        end else if (frame_last) begin
          state_d = S_DRAIN;
        end else if (LINE_GAP > 0) begin
          state_d = S_GAP;
          gap_d   = '0;
        end else begin
          state_d = S_STREAM;
          rd_en_d = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          col_d   = '0;
          row_d   = row_q + RW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_STREAM;
          rd_en_d = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          col_d   = '0;
          row_d   = row_q + RW'(1);
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        addr_d  = '0;
        col_d   = '0;
        row_d   = '0;
        gap_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort_i) begin
      state_d = S_IDLE;
      rd_en_d = 1'b0;
      addr_d  = '0;
      col_d   = '0;
      row_d   = '0;
      gap_d   = '0;
    end
  end

  // State, counters and both pipeline stages
  always_ff @(posedge pxl_clk or negedge pxl_rst_b) begin
    if (!pxl_rst_b) begin
      state_q <= S_IDLE;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      gap_q   <= '0;
      dv_q    <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      gap_q   <= gap_d;
      dv_q    <= dv_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
    end
  end

  assign sram_rd_en_o = rd_en_q;
  assign sram_addr_o  = addr_q;
  assign sof_o        = (state_q == S_SOF);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DRAIN) & ~abort_i;
  assign data_valid_o = dv_q;
  assign eol_o        = eol_q;
  assign eof_o        = eof_q;
  assign pxl_data_o   = dv_q ? sram_rdata_i : '0;

endmodule

// File: doc/conv1_pxl_streamer.md
Name: conv1_pxl_streamer

Overview:
- Frame source that drives the layer-1 conv/pool input side.
- Reads one IMG_W x IMG_H image from the pixel SRAM in raster order and generates the sof, data_valid and pixel stream that the layer-1 control FSM and line buffers consume.
- Produces optional inter-line gaps, end-of-line and end-of-frame flags, and a done pulse for the top-level sequencer.

Parameters:
- IMG_W, 32, pixels per line (>=2)
- IMG_H, 32, lines per frame (>=2)
- DATA_W, 8, pixel width
- ADDR_W, 10, SRAM address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
- LINE_GAP, 0, idle cycles inserted between lines, 0..15

Ports:
- pxl_clk  in  1  clock, rising edge
- pxl_rst_b  in  1  reset, asynchronous, active-low
- start_i  in  1  single-cycle request to stream one frame
- abort_i  in  1  synchronous frame abort
- sram_rd_en_o  out  1  SRAM read enable
- sram_addr_o  out  ADDR_W  SRAM read address
- sram_rdata_i  in  DATA_W  SRAM read data, valid 1 cycle after sram_rd_en_o
- sof_o  out  1  start of frame, 1-cycle pulse
- data_valid_o  out  1  pxl_data_o carries a valid pixel
- pxl_data_o  out  DATA_W  pixel data
- eol_o  out  1  qualifies the last pixel of each line
- eof_o  out  1  qualifies the last pixel of the frame
- busy_o  out  1  frame in progress
- done_o  out  1  1-cycle pulse, frame completed

Behaviour:
- Reset (async, active-low): state=IDLE. All outputs 0: sram_rd_en_o, sram_addr_o, sof_o, data_valid_o, pxl_data_o, eol_o, eof_o, busy_o, done_o. Column, row and gap counters cleared.
- Read side: sram_rd_en_o and sram_addr_o are registered outputs.
- Data side: data_valid_o, eol_o and eof_o equal the read-side rd_en/eol/eof delayed by exactly 1 cycle. pxl_data_o = sram_rdata_i when data_valid_o=1, else 0.
- FSM states:
  - IDLE: start_i=1 -> SOF; otherwise stay.
  - SOF (1 cycle): sof_o=1, busy_o=1, read issued at addr 0, col=0, row=0. Next state is STREAM.
  - STREAM: read issued each cycle, addr = previous+1, col increments.
    - Read with col=IMG_W-1 tags eol.
    - Tagged read with row=IMG_H-1 also tags eof.
    - After a tagged eol read: if last row -> DRAIN; else if LINE_GAP>0 -> GAP; else continue STREAM with col=0, row+1.
    - The first read of each line counts as part of SOF/STREAM/GAP-exit, so every line is exactly IMG_W reads.
  - GAP: no reads for exactly LINE_GAP cycles, then STREAM with col=0, row+1. The address continues from the last value +1.
  - DRAIN (1 cycle): no read; the final pixel appears with data_valid_o=eol_o=eof_o=1; done_o=1. Next state is IDLE.
- sof_o precedes the first data_valid_o by exactly 1 cycle.
- Frame length: last data_valid_o occurs IMG_W*IMG_H + (IMG_H-1)*LINE_GAP cycles after sof_o.
- busy_o: 1 in SOF, STREAM, GAP, DRAIN; 0 in IDLE.
- start_i while busy_o=1: ignored, no queueing.
- start_i in the same cycle as done_o: ignored; a new start is accepted only in IDLE.
- abort_i (any state): next cycle state=IDLE, counters cleared, sram_rd_en_o=0, no done_o. Any read issued in the abort cycle is still presented with data_valid_o the following cycle; the receiver discards it via its own frame reset. abort_i has priority over start_i.
- Reset mid-frame: immediate return to reset values; no partial done_o.
- Address never exceeds IMG_W*IMG_H-1; there is no wrap within a frame. The next frame restarts at 0.

Test Plan:
- IMG_W=4, IMG_H=3, LINE_GAP=0; start_i pulse -> sof_o at cycle T, sram_addr_o 0..11 on consecutive cycles T..T+11, data_valid_o T+1..T+12, eol_o at T+4/T+8/T+12, eof_o and done_o at T+12, busy_o low at T+13.
- Same with LINE_GAP=2 -> reads pause 2 cycles after addr 3 and after addr 7; last valid and done_o at T+16; pxl_data_o matches an SRAM model where pixel = addr.
- start_i re-pulsed at T+5 and again in the done_o cycle -> ignored; one frame only, busy_o drops after done_o.
- abort_i at T+6 (LINE_GAP=0) -> sram_rd_en_o=0 from T+7, last data_valid_o at T+7, no eof_o/done_o, busy_o=0 at T+7. A following start_i begins again at addr 0.
- pxl_rst_b asserted asynchronously mid-GAP -> all outputs 0 immediately. After release and start_i, a full 12-pixel frame completes correctly.
- Default parameters (32x32, gap 0) -> exactly 1024 valid pixels, 32 eol_o pulses, 1 eof_o pulse, max address 1023.
